// File: rtl/kb_step_counter.sv
// kb_step_counter
// Bounded up/down counter driven by PS/2 scan codes. It decodes make, break (F0)
// and extended (E0) prefixes and steps the count on the INC/DEC/CLR keys.
// Optional feature macro: KB_REPEAT_EN. When it is defined, typematic repeats
// of the key already held are applied as well.
module kb_step_counter #(
    parameter int unsigned      WIDTH     = 18,
    parameter logic [7:0]       INC_CODE  = 8'h1D,
    parameter logic [7:0]       DEC_CODE  = 8'h1B,
    parameter logic [7:0]       CLR_CODE  = 8'h2D,
    parameter logic [WIDTH-1:0] STEP      = WIDTH'(1),
    parameter logic [WIDTH-1:0] MIN_VAL   = '0,
    parameter logic [WIDTH-1:0] MAX_VAL   = '1,
    parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(1),
    parameter logic             SATURATE  = 1'b1
) (
    input  logic             CLOCK_50,
    input  logic             rst,
    input  logic [7:0]       scan_code,
    input  logic             scan_valid,
    output logic [WIDTH-1:0] count,
    output logic             evt_inc,
    output logic             evt_dec,
    output logic             evt_clr,
    output logic             at_max,
    output logic             at_min,
    output logic             held
);

    // Prefix decoder states
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_BRK     = 2'd1;
    localparam logic [1:0] ST_EXT     = 2'd2;
    localparam logic [1:0] ST_EXT_BRK = 2'd3;

    localparam logic [7:0] CODE_BRK = 8'hF0;
    localparam logic [7:0] CODE_EXT = 8'hE0;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             held_q, held_d;
    logic [7:0]       held_code_q, held_code_d;
    logic             evt_inc_q, evt_inc_d;
    logic             evt_dec_q, evt_dec_d;
    logic             evt_clr_q, evt_clr_d;

    logic             make_stb;
    logic             brk_stb;
    logic             is_clr, is_inc, is_dec, is_action;
    logic             is_repeat;
    logic             apply;
    logic [WIDTH:0]   inc_sum;
    logic [WIDTH:0]   dec_floor;
    logic [WIDTH-1:0] inc_val;
    logic [WIDTH-1:0] dec_val;

    // Prefix FSM: classifies each valid byte as a plain make, a break, or ignored
    always_comb begin
        state_d  = state_q;
        make_stb = 1'b0;
        brk_stb  = 1'b0;
        if (scan_valid) begin
            case (state_q)
                ST_IDLE: begin
                    if (scan_code == CODE_BRK) begin
                        state_d = ST_BRK;
                    end else if (scan_code == CODE_EXT) begin
                        state_d = ST_EXT;
                    end else begin
                        make_stb = 1'b1;
                    end
                end
                ST_BRK: begin
                    brk_stb = 1'b1;
                    state_d = ST_IDLE;
                end
                ST_EXT: begin
                    state_d = (scan_code == CODE_BRK) ? ST_EXT_BRK : ST_IDLE;
                end
                ST_EXT_BRK: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Action-key classification with CLR > INC > DEC priority on overlapping codes
    always_comb begin
        is_clr    = (scan_code == CLR_CODE);
        is_inc    = (scan_code == INC_CODE) && !is_clr;
        is_dec    = (scan_code == DEC_CODE) && !is_clr && !is_inc;
        is_action = is_clr || is_inc || is_dec;
    end

    // Typematic repeat filter: a make of the code already held is a repeat
    always_comb begin
`ifdef KB_REPEAT_EN
        is_repeat = 1'b0;
`else
        is_repeat = held_q && (scan_code == held_code_q);
`endif
        apply = make_stb && is_action && !is_repeat;
    end

    // Bounded step arithmetic, one bit wider so that overflow past MAX_VAL is visible
    always_comb begin
        inc_sum   = {1'b0, count_q} + {1'b0, STEP};
        dec_floor = {1'b0, MIN_VAL} + {1'b0, STEP};

        if (inc_sum > {1'b0, MAX_VAL}) begin
            inc_val = SATURATE ? MAX_VAL : MIN_VAL;
        end else begin
            inc_val = inc_sum[WIDTH-1:0];
        end

        if ({1'b0, count_q} < dec_floor) begin
            dec_val = SATURATE ? MIN_VAL : MAX_VAL;
        end else begin
            dec_val = count_q - STEP;
        end
    end

    // Counter, held tracking and one-cycle event pulses
    always_comb begin
        count_d     = count_q;
        held_d      = held_q;
        held_code_d = held_code_q;
        evt_inc_d   = 1'b0;
        evt_dec_d   = 1'b0;
        evt_clr_d   = 1'b0;

        if (make_stb && is_action) begin
            held_d      = 1'b1;
            held_code_d = scan_code;
        end

        if (brk_stb && (scan_code == held_code_q)) begin
            held_d = 1'b0;
        end

        if (apply) begin
            if (is_clr) begin
                count_d   = RESET_VAL;
                evt_clr_d = 1'b1;
            end else if (is_inc) begin
                count_d   = inc_val;
                evt_inc_d = 1'b1;
            end else begin
                count_d   = dec_val;
                evt_dec_d = 1'b1;
            end
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge CLOCK_50) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            count_q     <= RESET_VAL;
            held_q      <= 1'b0;
            held_code_q <= '0;
            evt_inc_q   <= 1'b0;
            evt_dec_q   <= 1'b0;
            evt_clr_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            held_q      <= held_d;
            held_code_q <= held_code_d;
            evt_inc_q   <= evt_inc_d;
            evt_dec_q   <= evt_dec_d;
            evt_clr_q   <= evt_clr_d;
        end
    end

    assign count   = count_q;
    assign evt_inc = evt_inc_q;
    assign evt_dec = evt_dec_q;
    assign evt_clr = evt_clr_q;
    assign held    = held_q;
    assign at_max  = (count_q == MAX_VAL);
    assign at_min  = (count_q == MIN_VAL);

endmodule

// File: tb/tb_kb_step_counter.sv
// Scoreboard bench for kb_step_counter: one default instance plus two narrow
// instances (saturating and wrapping) fed from the same scan-code stream.
module tb_kb_step_counter;

`ifdef KB_REPEAT_EN
    localparam bit R = 1'b1;
`else
    localparam bit R = 1'b0;
`endif

    localparam int E_NONE = 0;
    localparam int E_INC  = 1;
    localparam int E_DEC  = 2;
    localparam int E_CLR  = 4;

    localparam logic [17:0] A_MAX = 18'h3FFFF;

    logic        CLOCK_50 = 1'b0;
    logic        rst;
    logic [7:0]  scan_code;
    logic        scan_valid;

    logic [17:0] count_a;
    logic        inc_a, dec_a, clr_a, max_a, min_a, held_a;
    logic [3:0]  count_b;
    logic        inc_b, dec_b, clr_b, max_b, min_b, held_b;
    logic [3:0]  count_c;
    logic        inc_c, dec_c, clr_c, max_c, min_c, held_c;

    always #5 CLOCK_50 = ~CLOCK_50;

    kb_step_counter u_a (
        .CLOCK_50(CLOCK_50), .rst(rst), .scan_code(scan_code), .scan_valid(scan_valid),
        .count(count_a), .evt_inc(inc_a), .evt_dec(dec_a), .evt_clr(clr_a),
        .at_max(max_a), .at_min(min_a), .held(held_a)
    );

    kb_step_counter #(
        .WIDTH(4), .MIN_VAL(4'd2), .MAX_VAL(4'd15), .STEP(4'd4),
        .RESET_VAL(4'd14), .SATURATE(1'b1)
    ) u_b (
        .CLOCK_50(CLOCK_50), .rst(rst), .scan_code(scan_code), .scan_valid(scan_valid),
        .count(count_b), .evt_inc(inc_b), .evt_dec(dec_b), .evt_clr(clr_b),
        .at_max(max_b), .at_min(min_b), .held(held_b)
    );

    kb_step_counter #(
        .WIDTH(4), .MIN_VAL(4'd2), .MAX_VAL(4'd15), .STEP(4'd4),
        .RESET_VAL(4'd14), .SATURATE(1'b0)
    ) u_c (
        .CLOCK_50(CLOCK_50), .rst(rst), .scan_code(scan_code), .scan_valid(scan_valid),
        .count(count_c), .evt_inc(inc_c), .evt_dec(dec_c), .evt_clr(clr_c),
        .at_max(max_c), .at_min(min_c), .held(held_c)
    );

    typedef struct packed {
        logic [17:0] ca;
        logic [2:0]  ev;
        logic        h;
        logic [3:0]  cb;
        logic [3:0]  cc;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   n_checks = 0;
    int   n_pass   = 0;
    logic pend     = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // A response is due on the cycle after every byte accepted outside reset
    always @(posedge CLOCK_50) pend <= scan_valid && rst;

    always @(negedge CLOCK_50) begin
        if (pend) begin
            if (sb.size() == 0) begin
                n_checks++;
                $display("FAIL sb_underflow: got empty queue expected an entry");
            end else begin
                e = sb.pop_front();
                check("count_a", 32'(count_a), 32'(e.ca));
                check("evt_a",   32'({clr_a, dec_a, inc_a}), 32'(e.ev));
                check("evt_b",   32'({clr_b, dec_b, inc_b}), 32'(e.ev));
                check("evt_c",   32'({clr_c, dec_c, inc_c}), 32'(e.ev));
                check("held_a",  32'(held_a), 32'(e.h));
                check("held_b",  32'(held_b), 32'(e.h));
                check("at_max_a", 32'(max_a), 32'(e.ca == A_MAX));
                check("at_min_a", 32'(min_a), 32'(e.ca == 18'd0));
                check("count_b", 32'(count_b), 32'(e.cb));
                check("at_max_b", 32'(max_b), 32'(e.cb == 4'd15));
                check("at_min_b", 32'(min_b), 32'(e.cb == 4'd2));
                check("count_c", 32'(count_c), 32'(e.cc));
                check("held_c",  32'(held_c), 32'(e.h));
            end
        end else if (rst) begin
            check("idle_evt", 32'({clr_a, dec_a, inc_a, clr_b, dec_b, inc_b, clr_c, dec_c, inc_c}), 32'd0);
        end
    end

    task automatic send(input logic [7:0] c, input int ca, input int ev, input int h,
                        input int cb, input int cc);
        exp_t x;
        @(negedge CLOCK_50);
        scan_code  = c;
        scan_valid = 1'b1;
        x.ca = 18'(ca);
        x.ev = 3'(ev);
        x.h  = 1'(h);
        x.cb = 4'(cb);
        x.cc = 4'(cc);
        sb.push_back(x);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge CLOCK_50);
            scan_valid = 1'b0;
        end
    endtask

    task automatic reset_checks();
        check("rst_count_a", 32'(count_a), 32'd1);
        check("rst_evt_a",   32'({clr_a, dec_a, inc_a}), 32'd0);
        check("rst_held_a",  32'(held_a), 32'd0);
        check("rst_at_max_a", 32'(max_a), 32'd0);
        check("rst_at_min_a", 32'(min_a), 32'd0);
        check("rst_count_b", 32'(count_b), 32'd14);
        check("rst_count_c", 32'(count_c), 32'd14);
        check("rst_at_max_b", 32'(max_b), 32'd0);
    endtask

    initial begin
        int a8, b8, c8;
        rst        = 1'b0;
        scan_valid = 1'b0;
        scan_code  = 8'h00;
        repeat (2) @(negedge CLOCK_50);
        reset_checks();
        rst = 1'b1;

        // Single make, then typematic repeats, then break
        send(8'h1D, 2, E_INC, 1, 15, 2);
        send(8'h1D, R ? 3 : 2, R ? E_INC : E_NONE, 1, 15, R ? 6 : 2);
        send(8'h1D, R ? 4 : 2, R ? E_INC : E_NONE, 1, 15, R ? 10 : 2);
        send(8'hF0, R ? 4 : 2, E_NONE, 1, 15, R ? 10 : 2);
        send(8'h1D, R ? 4 : 2, E_NONE, 0, 15, R ? 10 : 2);
        idle(1);

        // Decrement make and its repeat, then a different action key while held
        send(8'h1B, R ? 3 : 1, E_DEC, 1, 11, R ? 6 : 15);
        send(8'h1B, R ? 2 : 1, R ? E_DEC : E_NONE, 1, R ? 7 : 11, R ? 2 : 15);
        a8 = R ? 3 : 2;
        b8 = R ? 11 : 15;
        c8 = R ? 6 : 2;
        send(8'h1D, a8, E_INC, 1, b8, c8);

        // Break of a non-held code keeps held; break of the held code releases it
        send(8'hF0, a8, E_NONE, 1, b8, c8);
        send(8'h1B, a8, E_NONE, 1, b8, c8);
        send(8'hF0, a8, E_NONE, 1, b8, c8);
        send(8'h1D, a8, E_NONE, 0, b8, c8);

        // Extended make, extended break and a stray break are all inert
        send(8'hE0, a8, E_NONE, 0, b8, c8);
        send(8'h1D, a8, E_NONE, 0, b8, c8);
        send(8'hE0, a8, E_NONE, 0, b8, c8);
        send(8'hF0, a8, E_NONE, 0, b8, c8);
        send(8'h1D, a8, E_NONE, 0, b8, c8);
        send(8'hF0, a8, E_NONE, 0, b8, c8);
        send(8'h1B, a8, E_NONE, 0, b8, c8);
        idle(2);

        // Clear, then walk down to the lower bounds
        send(8'h2D, 1, E_CLR, 1, 14, 14);
        send(8'hF0, 1, E_NONE, 1, 14, 14);
        send(8'h2D, 1, E_NONE, 0, 14, 14);
        send(8'h1B, 0, E_DEC, 1, 10, 10);
        send(8'hF0, 0, E_NONE, 1, 10, 10);
        send(8'h1B, 0, E_NONE, 0, 10, 10);
        send(8'h1B, 0, E_DEC, 1, 6, 6);
        send(8'hF0, 0, E_NONE, 1, 6, 6);
        send(8'h1B, 0, E_NONE, 0, 6, 6);
        send(8'h1B, 0, E_DEC, 1, 2, 2);
        send(8'hF0, 0, E_NONE, 1, 2, 2);
        send(8'h1B, 0, E_NONE, 0, 2, 2);
        send(8'h1B, 0, E_DEC, 1, 2, 15);
        send(8'hF0, 0, E_NONE, 1, 2, 15);
        send(8'h1B, 0, E_NONE, 0, 2, 15);

        // Non-action make has no effect
        send(8'h1C, 0, E_NONE, 0, 2, 15);

        // Pending break prefix, then reset colliding with a valid byte
        send(8'hF0, 0, E_NONE, 0, 2, 15);
        @(negedge CLOCK_50);
        rst        = 1'b0;
        scan_code  = 8'h1D;
        scan_valid = 1'b1;
        @(negedge CLOCK_50);
        scan_valid = 1'b0;
        reset_checks();
        rst = 1'b1;

        // The first byte after reset is a make, not a break
        send(8'h1D, 2, E_INC, 1, 15, 2);
        send(8'hE0, 2, E_NONE, 1, 15, 2);
        send(8'hF0, 2, E_NONE, 1, 15, 2);
        send(8'h1D, 2, E_NONE, 1, 15, 2);
        send(8'hF0, 2, E_NONE, 1, 15, 2);
        send(8'h1D, 2, E_NONE, 0, 15, 2);
        idle(5);

        check("sb_drain", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
